fifo_rd_arbiter: RTL and testbench

//   Read-side scheduler for the async FIFO (fifo1) in the rclk domain. Shares the single

---
 rtl/fifo_rd_arbiter.sv | 174 +++++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
//   Read-side scheduler for the async FIFO in the rclk domain. One FIFO read
//   port is shared among NREQ consumers using round-robin arbitration. Each
//   grant allows a burst of at most BURST words. Popped words pass through a
//   one-deep registered output stage and are tagged with the ID of the
//   consumer that owns them.
//
//   The controller has two states:
//     IDLE : no grant is active. A winner is picked from the pending requests,
//            and the grant is registered for the next cycle.
//     XFER : one consumer owns the read port. Words are popped while the FIFO
//            is non-empty, the owner keeps requesting, the burst budget is not
//            used up, and the output stage can take a new word.
//   At least one IDLE cycle separates two bursts. During that cycle the
//   round-robin pointer has already moved past the last owner.

module fifo_rd_arbiter #(
  parameter int DSIZE = 8,  // data word width (matches FIFO)
  parameter int NREQ  = 4,  // number of requesters
  parameter int IDW   = 2,  // requester ID width, clog2(NREQ)
  parameter int BURST = 4,  // max words popped per grant (>=1)
  parameter int CNTW  = 3   // burst counter width, clog2(BURST+1)
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  dready,
  output logic             rinc,
  output logic [NREQ-1:0]  gnt,
  output logic             dvalid,
  output logic [DSIZE-1:0] ddata,
  output logic [IDW-1:0]   did,
  output logic             busy
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  // Burst budget and the count value at which the last pop of a burst occurs.
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(BURST);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST - 1);

  // Highest requester ID. The pointer wraps to 0 after this value.
  localparam logic [IDW-1:0]  ID_LAST  = IDW'(NREQ - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]      state;     // IDLE / XFER
  logic [IDW-1:0]  cur;       // owner of the current grant
  logic [IDW-1:0]  rr;        // round-robin start point for the next search
  logic [CNTW-1:0] cnt;       // words popped in the current burst

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic            any_req;   // some consumer is requesting
  logic [IDW-1:0]  winner;    // first requester at or after rr, with wrap
  logic [NREQ-1:0] winner_oh; // one-hot form of winner
  logic            cur_req;   // current owner still requests
  logic            out_free;  // output stage can accept a word this cycle
  logic            pop;       // pop the FIFO head this cycle
  logic            burst_end; // leave XFER at the end of this cycle
  logic            in_xfer;

  // Round-robin search: the first set request, scanning upward from rr.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first. Without it, a path that skips the assignment infers a latch.
    any_req = 1'b0;
    winner  = rr;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = int'(rr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!any_req && req[k]) begin
        any_req = 1'b1;
        winner  = IDW'(k);
      end
    end
  end

  // Convert the winner ID to the one-hot grant vector.
  always_comb begin
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
  end

  // Pop qualification and burst termination for the active grant.
  always_comb begin
    in_xfer   = (state == XFER);
    cur_req   = req[cur];
    // A word may be popped when the stage is empty, or when the word
    // currently held is being taken by its consumer in this same cycle.
    out_free  = !dvalid || dready[did];
    pop       = in_xfer && !rempty && cur_req && (cnt < CNT_MAX) && out_free;
    // A grant ends after its last budgeted pop, or as soon as the owner stops
    // requesting. The owner can stop a burst that has no data (FIFO empty)
    // only by dropping its request.
    burst_end = in_xfer && ((pop && (cnt == CNT_LAST)) || !cur_req);
  end

  assign rinc = pop;
  assign busy = in_xfer;

  // ---------------------------------------------------------------------------
  // Grant controller: state, grant, owner, pointer and burst count
  // ---------------------------------------------------------------------------
  // Registers the arbitration result and tracks burst progress.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= IDLE;
      gnt   <= '0;
      cur   <= '0;
      rr    <= '0;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then samples values from before the clock edge, whatever
      // order the statements appear in.
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= XFER;
            gnt   <= winner_oh;
            cur   <= winner;
            cnt   <= '0;
          end
        end
        XFER: begin
          if (pop) begin
            cnt <= cnt + 1'b1;
          end
          if (burst_end) begin
            state <= IDLE;
            gnt   <= '0;
            rr    <= (cur == ID_LAST) ? '0 : cur + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // One-deep output stage
  // ---------------------------------------------------------------------------
  // Captures each popped word with its owner ID. The stage holds the word
  // under backpressure and empties once the word has been accepted.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      dvalid <= 1'b0;
      ddata  <= '0;
      did    <= '0;
    end else if (pop) begin
      // A pop can only occur when the stage is free or is being emptied this
      // cycle, so replacing the word here never loses data.
      dvalid <= 1'b1;
      ddata  <= rdata;
      did    <= cur;
    end else if (dvalid && dready[did]) begin
      dvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter
//   Directed bench for fifo_rd_arbiter. A queue acts as the FIFO read side:
//   rempty and rdata follow the queue head, and the queue pops when rinc was
//   high at a clock edge. Inputs change 1 ns after rclk rises. Outputs are
//   sampled on the falling edge.

module tb_fifo_rd_arbiter;

  localparam int DSIZE = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int BURST = 4;
  localparam int CNTW  = 3;

  logic             rclk   = 1'b0;
  logic             rrst_n = 1'b0;
  logic             rempty = 1'b1;
  logic [DSIZE-1:0] rdata  = '0;
  logic [NREQ-1:0]  req    = '0;
  logic [NREQ-1:0]  dready = '1;
  logic             rinc;
  logic [NREQ-1:0]  gnt;
  logic             dvalid;
  logic [DSIZE-1:0] ddata;
  logic [IDW-1:0]   did;
  logic             busy;

  int nvec = 0;
  int nerr = 0;

  logic [DSIZE-1:0] fifo_q[$];

  typedef struct {
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  dready;
    logic [NREQ-1:0]  gnt;
    logic             rinc;
    logic             dvalid;
    logic [DSIZE-1:0] ddata;
    logic [IDW-1:0]   did;
    logic             busy;
  } vec_t;

  vec_t vecs[$];

  fifo_rd_arbiter #(
    .DSIZE(DSIZE), .NREQ(NREQ), .IDW(IDW), .BURST(BURST), .CNTW(CNTW)
  ) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rempty (rempty),
    .rdata  (rdata),
    .req    (req),
    .dready (dready),
    .rinc   (rinc),
    .gnt    (gnt),
    .dvalid (dvalid),
    .ddata  (ddata),
    .did    (did),
    .busy   (busy)
  );

  always #5 rclk = ~rclk;

  function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] dr,
                              input logic [3:0] g, input logic ri,
                              input logic dv, input logic [7:0] dd,
                              input logic [1:0] id, input logic bz);
    vec_t v;
    v.req = rq; v.dready = dr; v.gnt = g; v.rinc = ri;
    v.dvalid = dv; v.ddata = dd; v.did = id; v.busy = bz;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic fifo_upd();
    rempty = (fifo_q.size() == 0);
    if (fifo_q.size() != 0) rdata = fifo_q[0];
    else                    rdata = '0;
  endtask

  task automatic fifo_load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
    fifo_upd();
  endtask

  // Advance one clock. Pops the model FIFO when rinc was high at the edge.
  task automatic advance();
    logic p;
    p = rinc;
    @(posedge rclk);
    #1;
    if (p) begin
      if (fifo_q.size() == 0) begin
        nerr++;
        $display("FAIL fifo_underflow: rinc=1 with empty FIFO at %0t", $time);
      end else begin
        void'(fifo_q.pop_front());
      end
    end
    fifo_upd();
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    req    = '0;
    dready = '1;
    fifo_q.delete();
    fifo_upd();
    @(posedge rclk);
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
  endtask

  // Check one cycle of outputs, then advance. ddata/did are compared only
  // when a valid word is expected.
  task automatic expect_cyc(input string tag, input logic [3:0] g,
                            input logic ri, input logic dv,
                            input logic [7:0] dd, input logic [1:0] id,
                            input logic bz);
    @(negedge rclk);
    check({tag, "_gnt"},    gnt,    g);
    check({tag, "_rinc"},   rinc,   ri);
    check({tag, "_dvalid"}, dvalid, dv);
    check({tag, "_busy"},   busy,   bz);
    if (dv) begin
      check({tag, "_ddata"}, ddata, dd);
      check({tag, "_did"},   did,   id);
    end
    advance();
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      req    = vecs[i].req;
      dready = vecs[i].dready;
      expect_cyc($sformatf("v%0d", i), vecs[i].gnt, vecs[i].rinc,
                 vecs[i].dvalid, vecs[i].ddata, vecs[i].did, vecs[i].busy);
    end
  endtask

  initial begin
    // Test 1: only req[1] set, FIFO holds 0x10..0x15 (vectors 0..10).
    vecs.push_back(mk(4'h2, 4'hf, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0));
    vecs.push_back(mk(4'h2, 4'hf, 4'h2, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1));
    vecs.push_back(mk(4'h2, 4'hf, 4'h2, 1'b1, 1'b1, 8'h10, 2'd1, 1'b1));
    vecs.push_back(mk(4'h2, 4'hf, 4'h2, 1'b1, 1'b1, 8'h11, 2'd1, 1'b1));
    vecs.push_back(mk(4'h2, 4'hf, 4'h2, 1'b1, 1'b1, 8'h12, 2'd1, 1'b1));
    vecs.push_back(mk(4'h2, 4'hf, 4'h0, 1'b0, 1'b1, 8'h13, 2'd1, 1'b0));
    vecs.push_back(mk(4'h2, 4'hf, 4'h2, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1));
    vecs.push_back(mk(4'h2, 4'hf, 4'h2, 1'b1, 1'b1, 8'h14, 2'd1, 1'b1));
    vecs.push_back(mk(4'h2, 4'hf, 4'h2, 1'b0, 1'b1, 8'h15, 2'd1, 1'b1));
    vecs.push_back(mk(4'h2, 4'hf, 4'h2, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1));
    vecs.push_back(mk(4'h2, 4'hf, 4'h2, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1));
    // Test 2: all requesting, FIFO holds 0..15 (vectors 11..32).
    // Each burst is one IDLE cycle followed by four popping XFER cycles.
    for (int b = 0; b < 4; b++) begin
      vecs.push_back(mk(4'hf, 4'hf, 4'h0, 1'b0, (b > 0), 8'(4*b - 1),
                        2'(b - 1), 1'b0));
      for (int k = 0; k < 4; k++)
        vecs.push_back(mk(4'hf, 4'hf, 4'(1 << b), 1'b1, (k > 0),
                          8'(4*b + k - 1), 2'(b), 1'b1));
    end
    vecs.push_back(mk(4'hf, 4'hf, 4'h0, 1'b0, 1'b1, 8'd15, 2'd3, 1'b0));
    vecs.push_back(mk(4'hf, 4'hf, 4'h1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1));

    // Reset state, with requests and data present to make it meaningful.
    rrst_n = 1'b0;
    req    = '1;
    dready = '1;
    fifo_load(8'h00, 4);
    @(negedge rclk);
    check("rst_gnt",    gnt,    4'h0);
    check("rst_rinc",   rinc,   1'b0);
    check("rst_dvalid", dvalid, 1'b0);
    check("rst_ddata",  ddata,  8'h00);
    check("rst_did",    did,    2'd0);
    check("rst_busy",   busy,   1'b0);

    // Test 1
    do_reset();
    fifo_load(8'h10, 6);
    run_vecs(0, 10);

    // Test 2
    do_reset();
    fifo_load(8'h00, 16);
    run_vecs(11, 32);

    // Test 3: backpressure for 3 cycles during a burst
    do_reset();
    fifo_load(8'h20, 8);
    req = 4'h1;
    expect_cyc("bp_idle", 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    expect_cyc("bp_w0",   4'h1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1);
    expect_cyc("bp_w1",   4'h1, 1'b1, 1'b1, 8'h20, 2'd0, 1'b1);
    dready = 4'he;
    for (int k = 0; k < 3; k++)
      expect_cyc($sformatf("bp_hold%0d", k), 4'h1, 1'b0, 1'b1, 8'h21, 2'd0, 1'b1);
    dready = 4'hf;
    expect_cyc("bp_resume", 4'h1, 1'b1, 1'b1, 8'h21, 2'd0, 1'b1);
    expect_cyc("bp_w3",     4'h1, 1'b1, 1'b1, 8'h22, 2'd0, 1'b1);
    expect_cyc("bp_end",    4'h0, 1'b0, 1'b1, 8'h23, 2'd0, 1'b0);

    // Test 4: FIFO runs dry after 2 words, refilled 5 cycles later
    do_reset();
    fifo_load(8'h30, 2);
    req = 4'h1;
    expect_cyc("em_idle", 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    expect_cyc("em_w0",   4'h1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1);
    expect_cyc("em_w1",   4'h1, 1'b1, 1'b1, 8'h30, 2'd0, 1'b1);
    for (int k = 0; k < 5; k++)
      expect_cyc($sformatf("em_starve%0d", k), 4'h1, 1'b0, (k == 0), 8'h31,
                 2'd0, 1'b1);
    fifo_load(8'h32, 2);
    expect_cyc("em_w2",  4'h1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1);
    expect_cyc("em_w3",  4'h1, 1'b1, 1'b1, 8'h32, 2'd0, 1'b1);
    expect_cyc("em_end", 4'h0, 1'b0, 1'b1, 8'h33, 2'd0, 1'b0);

    // Test 5: owner drops request after one word
    do_reset();
    fifo_load(8'h40, 8);
    req = 4'h6;
    expect_cyc("dr_idle", 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    expect_cyc("dr_w0",   4'h2, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1);
    req = 4'h4;
    expect_cyc("dr_drop", 4'h2, 1'b0, 1'b1, 8'h40, 2'd1, 1'b1);
    expect_cyc("dr_bub",  4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    expect_cyc("dr_next", 4'h4, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1);

    // Test 6: asynchronous reset mid-burst, then restart from pointer 0
    req = 4'hf;
    #2;
    rrst_n = 1'b0;
    #1;
    check("ar_gnt",    gnt,    4'h0);
    check("ar_rinc",   rinc,   1'b0);
    check("ar_dvalid", dvalid, 1'b0);
    check("ar_ddata",  ddata,  8'h00);
    check("ar_did",    did,    2'd0);
    check("ar_busy",   busy,   1'b0);
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    expect_cyc("ar_idle", 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
    expect_cyc("ar_gnt0", 4'h1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
